// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, buffer depth and fetch state type for fetch_unit and fetch_fifo
package fetch_pkg;
  localparam int INST_W = 26;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {RUN, FLUSH, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: FIFO_DEPTH-entry {inst, pc} buffer; ports clk, rst_n, push/wdata/wpc, pop, flush, rdata/rpc head, count, full, empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     wpc,
  output logic [INST_W-1:0] rdata,
  output logic [AW-1:0]     rpc,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [INST_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     mem_p [FIFO_DEPTH];
  logic [PW-1:0]     wp, rp;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_p[i] <= '0;
      end
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_d[wp] <= wdata;
        mem_p[wp] <= wpc;
        wp <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  assign rdata = mem_d[rp];
  assign rpc = mem_p[rp];
  assign full = count == CNT_W'(FIFO_DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited in-order instruction fetch; clk, rst_n, imem_req/addr/ready/rvalid/rdata, inst_valid/inst/inst_pc with dec_ready, redirect_valid/pc; FETCH_HALT_EN halts on 26'h3FFFFFF
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              dec_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);
  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] fetch_pc, resp_pc;
  logic [CNT_W-1:0]  outstanding, outstanding_n, count;
  logic              full, empty, push, pop, flush, halt_pop, acc, rsp, room;
  assign pop = inst_valid & dec_ready;
  assign rsp = imem_rvalid & (outstanding != '0);
  assign acc = imem_req & imem_ready;
  assign room = 32'(outstanding) + 32'(count) - 32'(pop) < FIFO_DEPTH;
  assign outstanding_n = outstanding + CNT_W'(acc) - CNT_W'(rsp);
`ifdef FETCH_HALT_EN
  assign halt_pop = pop & (&inst) & ~redirect_valid;
`else
  assign halt_pop = 1'b0;
`endif
  assign flush = redirect_valid | halt_pop;
  always_comb begin
    state_n = redirect_valid ? (outstanding_n != '0 ? FLUSH : RUN) :
              halt_pop ? HALT :
              (state == FLUSH && outstanding_n == '0) ? RUN : state;
    imem_req = rst_n && state == RUN && !redirect_valid && room;
    push = state == RUN && !redirect_valid && !halt_pop && rsp;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
    end else begin
      state <= state_n;
      outstanding <= outstanding_n;
      fetch_pc <= redirect_valid ? redirect_pc : fetch_pc + ADDR_W'(acc);
      resp_pc <= redirect_valid ? redirect_pc : resp_pc + ADDR_W'(push);
    end
  assign imem_addr = fetch_pc;
  assign inst_valid = ~empty;
  fetch_fifo #(.AW(ADDR_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(flush),
    .wdata(imem_rdata),
    .wpc(resp_pc),
    .rdata(inst),
    .rpc(inst_pc),
    .count(count),
    .full(full),
    .empty(empty)
  );
  a_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> outstanding != '0);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full || pop);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic checked against a queue-based model of the fetch rules
module tb_fetch_unit;
  localparam logic [15:0] RPC = 16'h0000;
  localparam int M_RUN = 0, M_FLUSH = 1, M_HALT = 2;
  typedef struct { logic [25:0] inst; logic [15:0] pc; } ent_t;
  typedef struct { logic [15:0] a; int due; } req_t;
  logic clk = 0, rst_n = 0, imem_ready = 0, imem_rvalid = 0, dec_ready = 0, redirect_valid = 0;
  logic [25:0] imem_rdata = '0;
  logic [15:0] redirect_pc = '0;
  logic imem_req, inst_valid;
  logic [15:0] imem_addr, inst_pc;
  logic [25:0] inst;
  int tests = 0, fails = 0, cyc = 0;
  int mode = M_RUN, disc = 0, lat_lo = 1, lat_hi = 1, rvp = 100;
  logic [15:0] m_fpc = RPC, m_rpc = RPC;
  ent_t q[$];
  req_t mq[$];

  fetch_unit #(.ADDR_W(16), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .dec_ready(dec_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] data_of(input logic [15:0] a);
    return a == 16'h0042 ? 26'h3FFFFFF : {a[9:0] ^ 10'h2A5, a};
  endfunction

  function automatic bit m_req();
    int pend;
    pend = mq.size() + q.size() - ((q.size() != 0 && dec_ready) ? 1 : 0);
    return mode == M_RUN && !redirect_valid && pend < 2;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      chk("rst_req", 64'(imem_req), 64'(0));
      chk("rst_valid", 64'(inst_valid), 64'(0));
      chk("rst_inst", 64'(inst), 64'(0));
      chk("rst_pc", 64'(inst_pc), 64'(0));
      chk("rst_addr", 64'(imem_addr), 64'(RPC));
    end else begin
      chk("req", 64'(imem_req), 64'(m_req()));
      chk("addr", 64'(imem_addr), 64'(m_fpc));
      chk("valid", 64'(inst_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("inst", 64'(inst), 64'(q[0].inst));
        chk("inst_pc", 64'(inst_pc), 64'(q[0].pc));
      end
    end
  end

  always @(posedge clk) begin
    bit pop, acc, rv;
    int prev;
    logic [15:0] ra;
    req_t r;
    ent_t e;
    if (!rst_n) begin
      mode = M_RUN; disc = 0; m_fpc = RPC; m_rpc = RPC;
      q.delete(); mq.delete();
    end else begin
      pop = q.size() != 0 && dec_ready;
      acc = m_req() && imem_ready;
      rv = imem_rvalid;
      ra = '0;
      if (rv) begin
        ra = mq[0].a;
        void'(mq.pop_front());
      end
      if (acc) begin
        r.a = m_fpc;
        r.due = cyc + int'($urandom_range(lat_hi, lat_lo));
        mq.push_back(r);
      end
      if (redirect_valid) begin
        q.delete();
        m_fpc = redirect_pc;
        m_rpc = redirect_pc;
        if (mode == M_FLUSH) disc = disc - (rv ? 1 : 0);
        else disc = mq.size();
        mode = disc != 0 ? M_FLUSH : M_RUN;
      end else begin
        prev = mode;
        if (pop) begin
`ifdef FETCH_HALT_EN
          if (q[0].inst == 26'h3FFFFFF) begin
            mode = M_HALT;
            q.delete();
          end else
`endif
          void'(q.pop_front());
        end
        if (rv) begin
          if (prev == M_RUN && mode == M_RUN) begin
            e.inst = data_of(ra);
            e.pc = m_rpc;
            q.push_back(e);
            m_rpc = m_rpc + 16'd1;
          end else if (prev == M_FLUSH) begin
            disc--;
            if (disc == 0) mode = M_RUN;
          end
        end
        if (acc) m_fpc = m_fpc + 16'd1;
      end
    end
    cyc++;
  end

  task automatic tick(input bit rdy, input bit drdy, input bit rd, input logic [15:0] rpc);
    @(negedge clk);
    imem_ready = rdy;
    dec_ready = drdy;
    redirect_valid = rd;
    redirect_pc = rpc;
    imem_rvalid = 1'b0;
    if (rst_n && mq.size() != 0) imem_rvalid = cyc >= mq[0].due && $urandom_range(99, 0) < rvp;
    imem_rdata = imem_rvalid ? data_of(mq[0].a) : 26'($urandom);
  endtask

  initial begin
    logic [15:0] wrap [3];
    int n;
    wrap[0] = 16'hFFFF; wrap[1] = 16'h0000; wrap[2] = 16'h0001;
    repeat (3) tick(0, 0, 0, '0);
    tick(1, 1, 0, '0);
    rst_n = 1;
    #3;
    chk("d0_req", 64'(imem_req), 64'(1));
    chk("d0_addr", 64'(imem_addr), 64'(0));
    for (int i = 1; i < 5; i++) begin
      tick(1, 1, 0, '0);
      #3;
      chk("d_req", 64'(imem_req), 64'(1));
      chk("d_addr", 64'(imem_addr), 64'(i));
      chk("d_valid", 64'(inst_valid), 64'(i >= 2));
      if (i >= 2) chk("d_pc", 64'(inst_pc), 64'(i - 2));
    end
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, '0);
      #3;
      chk("hold_req", 64'(imem_req), 64'(0));
      chk("hold_valid", 64'(inst_valid), 64'(1));
      chk("hold_pc", 64'(inst_pc), 64'(3));
      chk("hold_inst", 64'(inst), 64'(data_of(16'd3)));
    end
    rvp = 0;
    for (int i = 0; i < 20 && mq.size() < 2; i++) tick(1, 1, 0, '0);
    tick(1, 1, 1, 16'h0100);
    #3;
    chk("redir_req", 64'(imem_req), 64'(0));
    rvp = 100;
    for (int i = 0; i < 30; i++) begin
      tick(1, 1, 0, '0);
      #3;
      if (inst_valid) break;
    end
    chk("redir_valid", 64'(inst_valid), 64'(1));
    chk("redir_pc", 64'(inst_pc), 64'(16'h0100));
    chk("redir_inst", 64'(inst), 64'(data_of(16'h0100)));
    tick(1, 1, 1, 16'hFFFF);
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      tick(1, 1, 0, '0);
      #3;
      if (inst_valid) begin
        chk("wrap_pc", 64'(inst_pc), 64'(wrap[n]));
        n++;
      end
    end
    chk("wrap_seen", 64'(n), 64'(3));
    tick(1, 1, 1, 16'h0040);
    repeat (12) tick(1, 1, 0, '0);
    lat_lo = 1; lat_hi = 4; rvp = 70;
    repeat (3000) tick($urandom % 4 != 0, $urandom % 10 < 7, $urandom % 40 == 0, 16'($urandom));
    lat_lo = 1; lat_hi = 1; rvp = 0;
    for (int i = 0; i < 20 && mq.size() < 2; i++) tick(1, 1, 0, '0);
    @(negedge clk);
    #1;
    rst_n = 0;
    imem_rvalid = 0;
    #2;
    chk("arst_req", 64'(imem_req), 64'(0));
    chk("arst_valid", 64'(inst_valid), 64'(0));
    chk("arst_addr", 64'(imem_addr), 64'(RPC));
    repeat (2) tick(0, 0, 0, '0);
    rvp = 70;
    tick(1, 1, 0, '0);
    rst_n = 1;
    #3;
    chk("restart_req", 64'(imem_req), 64'(1));
    chk("restart_addr", 64'(imem_addr), 64'(RPC));
    lat_hi = 3;
    repeat (200) tick($urandom % 4 != 0, $urandom % 10 < 7, $urandom % 40 == 0, 16'($urandom));
    @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 16: width of PC and instruction-memory word address.
REQ-002 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  ADDR_W  word address of the request.
REQ-007 imem_ready  input  1  memory accepts the request when imem_req and imem_ready are both high.
REQ-008 imem_rvalid  input  1  read data valid; responses return in request order, at least 1 cycle after acceptance.
REQ-009 imem_rdata  input  26  fetched instruction word.
REQ-010 inst_valid  output  1  instruction available to decode.
REQ-011 inst  output  26  instruction to decode (feeds decoder inst input).
REQ-012 inst_pc  output  ADDR_W  address of inst.
REQ-013 dec_ready  input  1  decode consumes inst when inst_valid and dec_ready are both high.
REQ-014 redirect_valid  input  1  branch/jump redirect pulse.
REQ-015 redirect_pc  input  ADDR_W  redirect target address.

Function
REQ-016 The block SHALL have states RUN, FLUSH and HALT; reset enters RUN.
REQ-017 In RUN, imem_req SHALL be high iff outstanding + buffered < 2; imem_addr SHALL equal the fetch PC.
REQ-018 The fetch PC SHALL increment by 1 (mod 2^ADDR_W, wrapping to 0) on each accepted request.
REQ-019 Each in-order response SHALL push {imem_rdata, resp_pc} into a 2-entry FIFO; resp_pc SHALL increment by 1 per response.
REQ-020 inst_valid SHALL be high iff the FIFO is non-empty; inst/inst_pc SHALL show the FIFO head; the minimum latency is accept at cycle N, rvalid at N+1, inst_valid at N+2.
REQ-021 The FIFO SHALL support simultaneous push and pop in one cycle; the credit rule in REQ-017 guarantees it never overflows.
REQ-022 inst/inst_pc SHALL hold stable while inst_valid is high and dec_ready is low.
REQ-023 On redirect_valid, the block SHALL:
  - empty the FIFO;
  - load the fetch PC and resp_pc with redirect_pc;
  - set the discard count to the number of outstanding requests;
  - deassert imem_req in the same cycle;
  - go to FLUSH if the discard count is nonzero, else RUN.
REQ-024 The FIFO head SHALL count as consumed if dec_ready is high in the redirect cycle; inst_valid SHALL be low the cycle after.
REQ-025 In FLUSH, imem_req SHALL be low; each response SHALL be dropped and decrement the discard count; the block SHALL go to RUN when the count reaches 0.
REQ-026 A request accepted in the same cycle as redirect_valid SHALL be counted in the discard count.
REQ-027 A redirect during FLUSH SHALL reload both PCs and keep the current discard count.
REQ-028 imem_rvalid with zero outstanding requests SHALL be ignored and flagged by an assertion.

Reset
REQ-029 While rst_n is low, the outputs SHALL be:
  - imem_req=0 and inst_valid=0;
  - inst=0 and inst_pc=0;
  - imem_addr=RESET_PC.
REQ-030 Reset SHALL clear the FIFO, the outstanding count and the discard count; state SHALL be RUN; both PCs SHALL equal RESET_PC.
REQ-031 Reset mid-operation SHALL abandon all in-flight requests; the memory returns no responses for them after reset.

Configuration
REQ-032 With FETCH_HALT_EN defined, popping inst==26'h3FFFFFF SHALL move the block to HALT:
  - imem_req SHALL be low and responses SHALL be dropped;
  - a redirect SHALL leave HALT, using FLUSH rules.
REQ-033 Without FETCH_HALT_EN, the all-ones word SHALL be an ordinary instruction and HALT SHALL be unreachable.

Structure
REQ-034 Package fetch_pkg SHALL hold INST_W=26, FIFO_DEPTH=2 and the state enum fetch_state_t {RUN, FLUSH, HALT}.
REQ-035 The 2-entry buffer SHALL be a sub-module fetch_fifo (data+pc, push/pop/flush, full/empty).

Verification
REQ-036 Reset release, imem_ready=1, 1-cycle memory -> requests to 0,1,2; inst_valid from cycle 2; inst_pc 0,1,2 back-to-back.
REQ-037 dec_ready=0 for 5 cycles -> at most 2 requests outstanding+buffered; imem_req low; inst/inst_pc stable.
REQ-038 Redirect to 0x0100 with 2 outstanding -> both responses dropped; next inst_pc=0x0100; imem_req low until discard count is 0.
REQ-039 RESET_PC=0xFFFF -> addresses 0xFFFF, 0x0000, 0x0001.
REQ-040 FETCH_HALT_EN, word 26'h3FFFFFF at pc 3 -> imem_req stays low after the pop; redirect to 0x10 resumes at 0x10.
REQ-041 rst_n low while 2 requests are in flight -> all outputs at reset values asynchronously; fetch restarts at RESET_PC.
